imem_program_loader: RTL

//  Writer side of the instruction-memory interface. Receives a byte stream over a valid/ready link, packs bytes into
//  32-bit little-endian words and writes them into word-addressed I-MEM starting at address 0. Holds the core in reset

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/byte_word_packer.sv | 35 +++
 rtl/imem_program_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the I-MEM program loader: FSM state encoding and word geometry.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_RECV,
    LD_WRITE,
    LD_CHK,
    LD_DONE
  } ld_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream into little-endian words; word_full marks the byte that completes a word.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  output logic [8*BYTES_PER_WORD-1:0] word,
  output logic                        word_full
);

  localparam logic [BYTE_IDX_W-1:0] LastIdx = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [BYTE_IDX_W-1:0]       idx_q;
  logic [8*BYTES_PER_WORD-1:0] word_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (byte_valid) begin
      word_q[{idx_q, 3'b000} +: 8] <= byte_data;
      idx_q                        <= idx_q + BYTE_IDX_W'(1);
    end
  end

  assign word      = word_q;
  assign word_full = byte_valid && (idx_q == LastIdx);

endmodule

// File: rtl/imem_program_loader.sv
// Loads a byte stream into word-addressed I-MEM and holds the core in reset until done.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_program_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              chk_err
);

  localparam logic [ADDR_W:0] Depth  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CntOne = 1;

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic rx_ready_d, wr_en_d, core_reset_d, busy_d, done_d, error_d;
  logic accept, pack_valid, word_full, last_word, start_ok, pack_clear;

  assign accept     = rx_valid && rx_ready;
  assign pack_valid = accept && (state_q == LD_RECV);
  assign start_ok   = (word_count != '0) && (word_count <= Depth);
  assign last_word  = ({1'b0, word_idx_q} == (count_q - CntOne));

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_valid (pack_valid),
    .byte_data  (rx_data),
    .word       (imem_wr_data),
    .word_full  (word_full)
  );

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_e AfterLast = LD_CHK;

  logic [7:0] sum_q, sum_d;
  logic       chk_err_q, chk_err_d;
  logic       chk_pass;

  assign chk_pass = ((sum_q + rx_data) == 8'h00);

  always_comb begin
    sum_d     = sum_q;
    chk_err_d = chk_err_q;
    if (state_q == LD_IDLE && start && start_ok) begin
      sum_d     = '0;
      chk_err_d = 1'b0;
    end else if (pack_valid) begin
      sum_d = sum_q + rx_data;
    end else if (state_q == LD_CHK && accept && !chk_pass) begin
      chk_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  localparam ld_state_e AfterLast = LD_DONE;

  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LD_IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      rx_ready   <= 1'b0;
      imem_wr_en <= 1'b0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      rx_ready   <= rx_ready_d;
      imem_wr_en <= wr_en_d;
      core_reset <= core_reset_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

  assign imem_wr_addr = word_idx_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE:  if (start && start_ok) state_d = LD_RECV;
      LD_RECV:  if (word_full) state_d = LD_WRITE;
      LD_WRITE: state_d = last_word ? AfterLast : LD_RECV;
`ifdef LOADER_CHECKSUM_EN
      LD_CHK:   if (accept) state_d = chk_pass ? LD_DONE : LD_IDLE;
`endif
      LD_DONE:  state_d = LD_IDLE;
      default:  state_d = LD_IDLE;
    endcase
  end

  // Outputs are registered: their next values follow the upcoming state.
  always_comb begin
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    error_d      = error;
    core_reset_d = core_reset;
    pack_clear   = 1'b0;
    rx_ready_d   = (state_d == LD_RECV) || (state_d == LD_CHK);
    wr_en_d      = (state_d == LD_WRITE);
    busy_d       = (state_d != LD_IDLE);
    // A failed checksum also pulses done, but leaves the core in reset.
    done_d       = (state_d == LD_DONE) || (state_q == LD_CHK && state_d == LD_IDLE);
    case (state_q)
      LD_IDLE: begin
        if (start) begin
          if (start_ok) begin
            count_d      = word_count;
            word_idx_d   = '0;
            error_d      = 1'b0;
            core_reset_d = 1'b1;
            pack_clear   = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      LD_WRITE: begin
        pack_clear = 1'b1;
        if (!last_word) word_idx_d = word_idx_q + ADDR_W'(1);
      end
      LD_DONE:  core_reset_d = 1'b0;
      default:  ;
    endcase
  end

endmodule
